// File: rtl/crack_pkg.sv
// Shared types and default widths for the key-search scheduler.
package crack_pkg;

  localparam int unsigned DEF_KEY_W  = 24;
  localparam int unsigned DEF_ADDR_W = 8;
  localparam int unsigned DEF_DATA_W = 8;

  typedef enum logic [2:0] {
    StIdle,
    StWaitRdy,
    StLaunch,
    StRun,
    StDrain
  } sched_state_t;

endpackage

// File: rtl/ct_rr_arbiter.sv
// Round-robin arbiter for the shared single-port ciphertext memory.
// Grant is combinational from req; rvalid marks the returning read data.
module ct_rr_arbiter #(
  parameter int unsigned NUM_CORES = 2,
  parameter int unsigned ADDR_W    = 8
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [NUM_CORES-1:0]        i_req,
  input  logic [NUM_CORES*ADDR_W-1:0] i_addr,
  output logic [NUM_CORES-1:0]        o_gnt,
  output logic [ADDR_W-1:0]           o_ct_addr,
  output logic [NUM_CORES-1:0]        o_rvalid
);

  localparam int unsigned PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  logic [PTR_W-1:0]     r_ptr;
  logic [PTR_W-1:0]     w_ptr_d;
  logic [NUM_CORES-1:0] w_gnt;
  logic [ADDR_W-1:0]    w_addr;
  logic [NUM_CORES-1:0] r_rvalid;

  // Search requesters starting at the pointer; first hit wins and moves the pointer past it.
  always_comb begin
    int unsigned idx;
    int unsigned nxt;
    logic        found;
    w_gnt   = '0;
    w_addr  = '0;
    w_ptr_d = r_ptr;
    found   = 1'b0;
    idx     = 0;
    nxt     = 0;
    for (int unsigned k = 0; k < NUM_CORES; k++) begin
      idx = 32'(r_ptr) + k;
      if (idx >= NUM_CORES) begin
        idx = idx - NUM_CORES;
      end
      if (!found && i_req[idx]) begin
        found      = 1'b1;
        w_gnt[idx] = 1'b1;
        w_addr     = i_addr[idx*ADDR_W +: ADDR_W];
        nxt        = idx + 1;
        if (nxt == NUM_CORES) begin
          nxt = 0;
        end
        w_ptr_d = PTR_W'(nxt);
      end
    end
  end

  // Pointer and one-cycle-delayed grant (memory read latency).
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr    <= '0;
      r_rvalid <= '0;
    end else begin
      r_ptr    <= w_ptr_d;
      r_rvalid <= w_gnt;
    end
  end

  assign o_gnt     = w_gnt;
  assign o_ct_addr = w_addr;
  assign o_rvalid  = r_rvalid;

endmodule

// File: rtl/crack_sched.sv
// Scheduler running NUM_CORES interleaved key-search cores; first valid
// completion wins, the rest are aborted and drained.
module crack_sched
  import crack_pkg::*;
#(
  parameter int unsigned NUM_CORES = 2,
  parameter int unsigned KEY_W     = DEF_KEY_W,
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter int unsigned DATA_W    = DEF_DATA_W
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_en,
  output logic                        o_rdy,
  output logic [KEY_W-1:0]            o_key,
  output logic                        o_key_valid,
  output logic [ADDR_W-1:0]           o_ct_addr,
  input  logic [DATA_W-1:0]           i_ct_rddata,
  output logic [NUM_CORES-1:0]        o_core_en,
  input  logic [NUM_CORES-1:0]        i_core_rdy,
  output logic [NUM_CORES*KEY_W-1:0]  o_core_key_start,
  output logic [KEY_W-1:0]            o_core_key_stride,
  input  logic [NUM_CORES*KEY_W-1:0]  i_core_key,
  input  logic [NUM_CORES-1:0]        i_core_key_valid,
  output logic [NUM_CORES-1:0]        o_core_abort,
  input  logic [NUM_CORES-1:0]        i_core_ct_req,
  input  logic [NUM_CORES*ADDR_W-1:0] i_core_ct_addr,
  output logic [NUM_CORES-1:0]        o_core_ct_gnt,
  output logic [DATA_W-1:0]           o_core_ct_rddata,
  output logic [NUM_CORES-1:0]        o_core_ct_rvalid
);

  sched_state_t         r_state, w_state_d;
  logic [KEY_W-1:0]     r_key, w_key_d;
  logic                 r_key_valid, w_key_valid_d;
  logic [NUM_CORES-1:0] r_busy, w_busy_d;
  logic [NUM_CORES-1:0] r_done, w_done_d;
  logic [NUM_CORES-1:0] w_complete;
  logic [NUM_CORES-1:0] w_win;
  logic                 w_win_found;
  logic [KEY_W-1:0]     w_win_key;

  // Static key-space interleave: core i starts at i and steps by NUM_CORES.
  for (genvar g = 0; g < NUM_CORES; g++) begin : g_key_start
    assign o_core_key_start[g*KEY_W +: KEY_W] = KEY_W'(g);
  end
  assign o_core_key_stride = KEY_W'(NUM_CORES);

  // A core completes when it was seen busy and is now back at rdy.
  assign w_complete = r_busy & i_core_rdy & ~r_done;
  assign w_win      = w_complete & i_core_key_valid;

  // Pick the lowest-index valid completion.
  always_comb begin
    w_win_found = 1'b0;
    w_win_key   = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (!w_win_found && w_win[i]) begin
        w_win_found = 1'b1;
        w_win_key   = i_core_key[i*KEY_W +: KEY_W];
      end
    end
  end

  // Next-state logic for the search FSM and result registers.
  always_comb begin
    w_state_d     = r_state;
    w_key_d       = r_key;
    w_key_valid_d = r_key_valid;
    w_busy_d      = r_busy;
    w_done_d      = r_done;
    case (r_state)
      StIdle: begin
        if (i_en) begin
          w_key_d       = '0;
          w_key_valid_d = 1'b0;
          w_busy_d      = '0;
          w_done_d      = '0;
          w_state_d     = StWaitRdy;
        end
      end
      StWaitRdy: begin
        if (&i_core_rdy) begin
          w_state_d = StLaunch;
        end
      end
      StLaunch: begin
        w_state_d = StRun;
      end
      StRun: begin
        w_busy_d = r_busy | ~i_core_rdy;
        w_done_d = r_done | w_complete;
        if (w_win_found) begin
          w_key_d       = w_win_key;
          w_key_valid_d = 1'b1;
          w_state_d     = StDrain;
        end else if (&w_done_d) begin
          // Every core exhausted its share without a hit.
          w_key_valid_d = 1'b0;
          w_state_d     = StIdle;
        end
      end
      StDrain: begin
        if (&i_core_rdy) begin
          w_state_d = StIdle;
        end
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  // State and result registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= StIdle;
      r_key       <= '0;
      r_key_valid <= 1'b0;
      r_busy      <= '0;
      r_done      <= '0;
    end else begin
      r_state     <= w_state_d;
      r_key       <= w_key_d;
      r_key_valid <= w_key_valid_d;
      r_busy      <= w_busy_d;
      r_done      <= w_done_d;
    end
  end

  assign o_rdy        = (r_state == StIdle);
  assign o_key        = r_key;
  assign o_key_valid  = r_key_valid;
  assign o_core_en    = {NUM_CORES{r_state == StLaunch}};
  assign o_core_abort = {NUM_CORES{r_state == StDrain}};

  assign o_core_ct_rddata = i_ct_rddata;

  ct_rr_arbiter #(
    .NUM_CORES (NUM_CORES),
    .ADDR_W    (ADDR_W)
  ) u_arb (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_req     (i_core_ct_req),
    .i_addr    (i_core_ct_addr),
    .o_gnt     (o_core_ct_gnt),
    .o_ct_addr (o_ct_addr),
    .o_rvalid  (o_core_ct_rvalid)
  );

endmodule

// File: tb/tb_crack_sched.sv
// Bench for crack_sched with NUM_CORES=2; cores are modelled by direct stimulus.
module tb_crack_sched;

  localparam int unsigned N      = 2;
  localparam int unsigned KEY_W  = 24;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 8;

  logic                 clk;
  logic                 rst;
  logic                 en;
  logic                 rdy;
  logic [KEY_W-1:0]     key;
  logic                 key_valid;
  logic [ADDR_W-1:0]    ct_addr;
  logic [DATA_W-1:0]    ct_rddata;
  logic [N-1:0]         core_en;
  logic [N-1:0]         core_rdy;
  logic [N*KEY_W-1:0]   core_key_start;
  logic [KEY_W-1:0]     core_key_stride;
  logic [N*KEY_W-1:0]   core_key;
  logic [N-1:0]         core_key_valid;
  logic [N-1:0]         core_abort;
  logic [N-1:0]         core_ct_req;
  logic [N*ADDR_W-1:0]  core_ct_addr;
  logic [N-1:0]         core_ct_gnt;
  logic [DATA_W-1:0]    core_ct_rddata;
  logic [N-1:0]         core_ct_rvalid;

  int n_checks;
  int n_pass;

  // Scoreboards: search results {valid, key} and expected rvalid vectors.
  logic [KEY_W:0] q_res[$];
  logic [N-1:0]   q_rv[$];

  crack_sched #(
    .NUM_CORES (N),
    .KEY_W     (KEY_W),
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W)
  ) dut (
    .i_clk             (clk),
    .i_rst             (rst),
    .i_en              (en),
    .o_rdy             (rdy),
    .o_key             (key),
    .o_key_valid       (key_valid),
    .o_ct_addr         (ct_addr),
    .i_ct_rddata       (ct_rddata),
    .o_core_en         (core_en),
    .i_core_rdy        (core_rdy),
    .o_core_key_start  (core_key_start),
    .o_core_key_stride (core_key_stride),
    .i_core_key        (core_key),
    .i_core_key_valid  (core_key_valid),
    .o_core_abort      (core_abort),
    .i_core_ct_req     (core_ct_req),
    .i_core_ct_addr    (core_ct_addr),
    .o_core_ct_gnt     (core_ct_gnt),
    .o_core_ct_rddata  (core_ct_rddata),
    .o_core_ct_rvalid  (core_ct_rvalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse en and wait (bounded) for the launch, then make both cores busy.
  task automatic start_search();
    int cnt;
    en = 1'b1;
    tick();
    en = 1'b0;
    cnt = 0;
    while (core_en !== 2'b11 && cnt < 8) begin
      tick();
      cnt++;
    end
    n_checks++;
    if (cnt >= 8) $display("FAIL start_search: core_en=%b never reached 11", core_en);
    else n_pass++;
    tick();
    core_rdy       = 2'b00;
    core_key_valid = 2'b00;
    tick();
  endtask

  // Bounded wait for rdy, then compare the result against the scoreboard head.
  task automatic wait_result(input string name);
    int cnt;
    logic [KEY_W:0] exp;
    cnt = 0;
    while (rdy !== 1'b1 && cnt < 16) begin
      tick();
      cnt++;
    end
    exp = q_res.pop_front();
    n_checks++;
    if (cnt >= 16) $display("FAIL %s: rdy timeout", name);
    else if ({key_valid, key} !== exp)
      $display("FAIL %s: got valid=%b key=%h, want valid=%b key=%h", name, key_valid, key,
               exp[KEY_W], exp[KEY_W-1:0]);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n_checks++; if (rdy !== 1'b1) $display("FAIL reset_rdy: got %b want 1", rdy); else n_pass++;
    n_checks++;
    if (key_valid !== 1'b0) $display("FAIL reset_kv: got %b want 0", key_valid); else n_pass++;
    n_checks++; if (key !== '0) $display("FAIL reset_key: got %h want 0", key); else n_pass++;
    n_checks++;
    if (core_en !== 2'b00) $display("FAIL reset_core_en: got %b want 00", core_en); else n_pass++;
    n_checks++;
    if (core_abort !== 2'b00) $display("FAIL reset_abort: got %b want 00", core_abort);
    else n_pass++;
    n_checks++;
    if (core_ct_gnt !== 2'b00) $display("FAIL reset_gnt: got %b want 00", core_ct_gnt);
    else n_pass++;
    tick();
    n_checks++;
    if (core_ct_rvalid !== 2'b00) $display("FAIL reset_rvalid: got %b want 00", core_ct_rvalid);
    else n_pass++;
  endtask

  // Round-robin model: pointer p, grant first requester at or after p.
  task automatic test_arbiter();
    logic [1:0] req_pat [6];
    int p;
    logic [N-1:0] exp_gnt;
    logic [ADDR_W-1:0] exp_addr;
    logic [N-1:0] exp_rv;
    req_pat = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b10, 2'b01};
    p = 0;
    core_ct_addr = {8'd9, 8'd5};
    ct_rddata = 8'h5A;
    for (int c = 0; c < 6; c++) begin
      core_ct_req = req_pat[c];
      #1;
      exp_gnt = '0;
      exp_addr = '0;
      if (core_ct_req[p]) begin
        exp_gnt[p] = 1'b1;
        exp_addr = (p == 0) ? 8'd5 : 8'd9;
        p = (p + 1) % N;
      end else if (core_ct_req[(p + 1) % N]) begin
        exp_gnt[(p + 1) % N] = 1'b1;
        exp_addr = (((p + 1) % N) == 0) ? 8'd5 : 8'd9;
        p = (p + 2) % N;
      end
      q_rv.push_back(exp_gnt);
      n_checks++;
      if (core_ct_gnt !== exp_gnt)
        $display("FAIL arb_gnt[%0d]: got %b want %b", c, core_ct_gnt, exp_gnt);
      else n_pass++;
      n_checks++;
      if (ct_addr !== exp_addr)
        $display("FAIL arb_addr[%0d]: got %0d want %0d", c, ct_addr, exp_addr);
      else n_pass++;
      tick();
      exp_rv = q_rv.pop_front();
      n_checks++;
      if (core_ct_rvalid !== exp_rv)
        $display("FAIL arb_rvalid[%0d]: got %b want %b", c, core_ct_rvalid, exp_rv);
      else n_pass++;
    end
    core_ct_req = 2'b00;
    #1;
    n_checks++;
    if (core_ct_gnt !== 2'b00 || ct_addr !== 8'd0)
      $display("FAIL arb_idle: got gnt=%b addr=%0d want 00/0", core_ct_gnt, ct_addr);
    else n_pass++;
    n_checks++;
    if (core_ct_rddata !== 8'h5A)
      $display("FAIL arb_rddata: got %h want 5a", core_ct_rddata);
    else n_pass++;
    tick();
  endtask

  // Exact launch timing; leaves both cores busy in RUN.
  task automatic test_launch();
    en = 1'b1;
    tick();
    en = 1'b0;
    n_checks++;
    if (core_en !== 2'b00) $display("FAIL launch_early: got %b want 00", core_en); else n_pass++;
    tick();
    n_checks++;
    if (core_en !== 2'b11) $display("FAIL launch_en: got %b want 11", core_en); else n_pass++;
    n_checks++;
    if (core_key_start !== {24'd1, 24'd0})
      $display("FAIL launch_start: got %h want %h", core_key_start, {24'd1, 24'd0});
    else n_pass++;
    n_checks++;
    if (core_key_stride !== 24'd2)
      $display("FAIL launch_stride: got %0d want 2", core_key_stride);
    else n_pass++;
    tick();
    n_checks++;
    if (core_en !== 2'b00) $display("FAIL launch_pulse: got %b want 00", core_en); else n_pass++;
    core_rdy = 2'b00;
    tick();
  endtask

  task automatic test_single_winner();
    core_key       = {24'h00A3F1, 24'h000777};
    core_key_valid = 2'b10;
    core_rdy       = 2'b10;
    q_res.push_back({1'b1, 24'h00A3F1});
    tick();
    core_key_valid = 2'b00;
    for (int c = 0; c < 3; c++) begin
      n_checks++;
      if (core_abort !== 2'b11 || rdy !== 1'b0)
        $display("FAIL win_drain[%0d]: got abort=%b rdy=%b want 11/0", c, core_abort, rdy);
      else n_pass++;
      tick();
    end
    n_checks++;
    if (key !== 24'h00A3F1 || key_valid !== 1'b1)
      $display("FAIL win_key: got %h/%b want 00a3f1/1", key, key_valid);
    else n_pass++;
    core_rdy = 2'b11;
    tick();
    n_checks++;
    if (rdy !== 1'b1 || core_abort !== 2'b00)
      $display("FAIL win_release: got rdy=%b abort=%b want 1/00", rdy, core_abort);
    else n_pass++;
    wait_result("win_result");
  endtask

  task automatic test_simultaneous();
    start_search();
    core_key       = {24'h000011, 24'h000010};
    core_key_valid = 2'b11;
    core_rdy       = 2'b11;
    q_res.push_back({1'b1, 24'h000010});
    tick();
    core_key_valid = 2'b00;
    n_checks++;
    if (core_abort !== 2'b11) $display("FAIL sim_drain: got abort=%b want 11", core_abort);
    else n_pass++;
    wait_result("sim_result");
  endtask

  task automatic test_all_invalid();
    start_search();
    core_key       = {24'h000055, 24'h000066};
    core_key_valid = 2'b00;
    core_rdy       = 2'b11;
    q_res.push_back({1'b0, 24'h000000});
    tick();
    n_checks++;
    if (rdy !== 1'b1 || core_abort !== 2'b00)
      $display("FAIL inv_idle: got rdy=%b abort=%b want 1/00", rdy, core_abort);
    else n_pass++;
    wait_result("inv_result");
  endtask

  task automatic test_reset_mid_run();
    start_search();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    core_rdy = 2'b11;
    n_checks++;
    if (rdy !== 1'b1 || core_en !== 2'b00 || core_abort !== 2'b00 || key_valid !== 1'b0)
      $display("FAIL mid_rst: got rdy=%b en=%b abort=%b kv=%b want 1/00/00/0",
               rdy, core_en, core_abort, key_valid);
    else n_pass++;
    tick();
    n_checks++;
    if (rdy !== 1'b1 || core_en !== 2'b00)
      $display("FAIL mid_rst_hold: got rdy=%b en=%b want 1/00", rdy, core_en);
    else n_pass++;
  endtask

  initial begin
    n_checks       = 0;
    n_pass         = 0;
    rst            = 1'b1;
    en             = 1'b0;
    ct_rddata      = '0;
    core_rdy       = 2'b11;
    core_key       = '0;
    core_key_valid = 2'b00;
    core_ct_req    = 2'b00;
    core_ct_addr   = '0;
    test_reset();
    test_arbiter();
    test_launch();
    test_single_winner();
    test_simultaneous();
    test_all_invalid();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/crack_sched.md
Name: crack_sched

Overview:
- Top-level scheduler that runs NUM_CORES key-search cores in parallel over an interleaved 24-bit key space.
- Each core gets start key i and stride NUM_CORES. Cores share one single-port ciphertext memory through a round-robin arbiter.
- The first core to report a valid key wins. All others are aborted and drained, and the winning key is presented on a single en/rdy interface identical in style to one search core.

Parameters:
- NUM_CORES, 2, number of search cores controlled (2..8).
- KEY_W, 24, key width.
- ADDR_W, 8, ciphertext memory address width.
- DATA_W, 8, ciphertext memory data width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- en  in  1  start a search; sampled only when rdy=1.
- rdy  out  1  high in IDLE only.
- key  out  KEY_W  winning key; 0 unless key_valid.
- key_valid  out  1  last search found a key; held until next accepted en.
- ct_addr  out  ADDR_W  shared ct memory address.
- ct_rddata  in  DATA_W  ct memory read data, 1-cycle latency.
- core_en  out  NUM_CORES  one-cycle start pulse per core.
- core_rdy  in  NUM_CORES  core idle.
- core_key_start  out  NUM_CORES*KEY_W  per-core first key, slice i = i.
- core_key_stride  out  KEY_W  = NUM_CORES, constant.
- core_key  in  NUM_CORES*KEY_W  per-core result key.
- core_key_valid  in  NUM_CORES  per-core result valid; qualified by that core's completion.
- core_abort  out  NUM_CORES  level; core must return to rdy within its own bounded time.
- core_ct_req  in  NUM_CORES  ct read request, held until granted.
- core_ct_addr  in  NUM_CORES*ADDR_W  requested address.
- core_ct_gnt  out  NUM_CORES  one-hot grant, combinational from req in the same cycle.
- core_ct_rddata  out  DATA_W  ct_rddata broadcast to all cores.
- core_ct_rvalid  out  NUM_CORES  one-hot, high the cycle after the matching grant.

Behaviour:
- Reset values:
  - FSM=IDLE; rdy=1.
  - key=0, key_valid=0.
  - core_en=0, core_abort=0.
  - gnt=0, rvalid=0, rr pointer=0, done/busy masks=0.
- Reset mid-operation: same values on the next edge. Cores are reset by the same rst; no abort sequence is run.
- FSM states:
  - IDLE: on en, clear key_valid/key/masks and go to WAITRDY.
  - WAITRDY: wait until &core_rdy, then go to LAUNCH.
  - LAUNCH: core_en all-ones for exactly 1 cycle, then go to RUN.
  - RUN: watch for completions (below).
  - DRAIN: core_abort all-ones until &core_rdy, then go to IDLE. core_abort drops in IDLE.
- RUN completion tracking:
  - busy[i] sets when core_rdy[i]=0 is seen.
  - done[i] sets when busy[i]=1 and core_rdy[i]=1.
  - On the first cycle any core completes with core_key_valid[i]=1: latch key=core_key[i], key_valid=1, go to DRAIN.
  - Simultaneous valid completions: lowest index wins.
  - A core completing with core_key_valid=0 only sets done[i].
  - All done[] set and none valid: key_valid=0, go directly to IDLE.
- Latency: en to first core_en is 2 cycles when all cores are idle. Winning completion to rdy is 1 cycle plus drain time.
- Arbiter:
  - Active in every state.
  - Grants at most one requester per cycle, round-robin starting at pointer p.
  - ct_addr = core_ct_addr of the granted core; 0 when no grant.
  - After grant to core g, p = (g+1) mod NUM_CORES. With no request, p is unchanged.
  - rvalid[g] is high the following cycle.
- Width rules: core_key_start slice i = i zero-extended to KEY_W. Stride is a KEY_W constant. Key space wrap is handled by the cores; this block does no arithmetic on keys.

Decomposition:
- crack_pkg:
  - sched_state_t enum: IDLE, WAITRDY, LAUNCH, RUN, DRAIN.
  - KEY_W, ADDR_W, DATA_W defaults.
- Sub-module ct_rr_arbiter (NUM_CORES, ADDR_W): req/addr in; gnt, ct_addr, rvalid out; owns pointer and rvalid register.

Test Plan:
- Reset, then idle: rdy=1, key_valid=0, key=0, core_en=0, core_abort=0, gnt=0.
- NUM_CORES=2, both cores idle, en pulse: core_en=2'b11 for 1 cycle two cycles after en; core_key_start = {24'd1, 24'd0}; stride=2.
- Core1 completes valid with key 24'h00A3F1 while core0 is still busy: key=24'h00A3F1, key_valid=1, core_abort=2'b11 until core0 rdy, then rdy=1 next cycle.
- Both cores complete valid in the same cycle with keys 0x10 and 0x11: key=0x10 (core0 wins).
- Both cores complete invalid: key_valid=0, key=0, rdy=1, no abort asserted.
- core_ct_req=2'b11 held for 4 cycles with addrs 5 and 9, p=0: grants 01,10,01,10; ct_addr 5,9,5,9; rvalid follows each grant by 1 cycle.
- rst asserted mid-RUN: next cycle rdy=1, core_en=0, core_abort=0, key_valid=0.
